// File: rtl/multicycle_control_unit_pkg.sv
// rtl/multicycle_control_unit_pkg.sv - cu_pkg: states, opcode/funct codes, ALU and mux select encodings
package cu_pkg;

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_ERROR
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - unified memory port request/ready handshake
interface multicycle_control_unit_if;
    logic MEM_REQ;
    logic MEM_WRITE;
    logic MEM_READY;

    modport master (output MEM_REQ, output MEM_WRITE, input MEM_READY);
    modport slave  (input MEM_REQ, input MEM_WRITE, output MEM_READY);
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// rtl/multicycle_control_unit_alu_decoder.sv - R-type FUNCT to ALU operation with valid flag
module alu_decoder
    import cu_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_op_o,
    output logic       valid_o
);
    always_comb begin
        alu_op_o = ALU_AND;
        valid_o  = 1'b1;
        case (funct_i)
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_SLT:  alu_op_o = ALU_SLT;
            default: valid_o  = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle MIPS control FSM with memory timeout; CU_BNE_EN adds bne
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int ALU_OP_W       = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [5:0]          OPCODE,
    input  logic [5:0]          FUNCT,
    input  logic                ZERO,
    multicycle_control_unit_if.master mem,
    output logic                I_OR_D,
    output logic                IR_WRITE,
    output logic                PC_WRITE,
    output logic [1:0]          PC_SRC,
    output logic                REG_DST,
    output logic                REG_WRITE,
    output logic                MEM2REG,
    output logic                EX_TOP,
    output logic                ALU_SRC_A,
    output logic [1:0]          ALU_SRC_B,
    output logic [ALU_OP_W-1:0] ALU_OP,
    output logic                ILLEGAL,
    output logic                ERR
);
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mem_req, mem_write, wait_st;
    logic [3:0] alu_op, dec_op;
    logic       dec_valid;
`ifdef CU_BNE_EN
    logic       bne_q, bne_d;
`endif

    alu_decoder u_alu_decoder (.funct_i(FUNCT), .alu_op_o(dec_op), .valid_o(dec_valid));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_START;
            cnt_q   <= 8'd0;
`ifdef CU_BNE_EN
            bne_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef CU_BNE_EN
            bne_q   <= bne_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        I_OR_D    = 1'b0;
        IR_WRITE  = 1'b0;
        PC_WRITE  = 1'b0;
        PC_SRC    = PCSRC_ALU;
        REG_DST   = 1'b0;
        REG_WRITE = 1'b0;
        MEM2REG   = 1'b0;
        EX_TOP    = 1'b0;
        ALU_SRC_A = 1'b0;
        ALU_SRC_B = SRCB_RT;
        alu_op    = ALU_AND;
        ILLEGAL   = 1'b0;
        ERR       = 1'b0;
`ifdef CU_BNE_EN
        bne_d     = bne_q;
`endif
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                ALU_SRC_B = SRCB_FOUR;
                alu_op    = ALU_ADD;
                if (mem.MEM_READY) begin
                    IR_WRITE = 1'b1;
                    PC_WRITE = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here so BRANCH only needs the compare
                ALU_SRC_B = SRCB_IMM_SH2;
                alu_op    = ALU_ADD;
                EX_TOP    = 1'b1;
`ifdef CU_BNE_EN
                bne_d     = (OPCODE == OP_BNE);
`endif
                case (OPCODE)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef CU_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        ILLEGAL = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                ALU_SRC_A = 1'b1;
                ALU_SRC_B = SRCB_IMM;
                alu_op    = ALU_ADD;
                if (state_q == S_ADDIEX)  state_d = S_ADDIWB;
                else if (OPCODE == OP_LW) state_d = S_MEMRD;
                else                      state_d = S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                I_OR_D  = 1'b1;
                if (mem.MEM_READY) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                REG_WRITE = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                I_OR_D    = 1'b1;
                if (mem.MEM_READY) state_d = S_FETCH;
            end
            S_EXEC: begin
                ALU_SRC_A = 1'b1;
                if (dec_valid) begin
                    alu_op  = dec_op;
                    state_d = S_ALUWB;
                end else begin
                    ILLEGAL = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_ALUWB, S_ADDIWB: begin
                REG_WRITE = 1'b1;
                REG_DST   = (state_q == S_ALUWB);
                MEM2REG   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALU_SRC_A = 1'b1;
                alu_op    = ALU_SUB;
                PC_SRC    = PCSRC_ALUOUT;
`ifdef CU_BNE_EN
                PC_WRITE  = bne_q ? ~ZERO : ZERO;
`else
                PC_WRITE  = ZERO;
`endif
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                PC_SRC   = PCSRC_JUMP;
                PC_WRITE = 1'b1;
                state_d  = S_FETCH;
            end
            S_ERROR: ERR = 1'b1;
            default: state_d = S_START;
        endcase

        wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        if (wait_st && !mem.MEM_READY && (cnt_q == 8'(TIMEOUT_CYCLES)))
            state_d = S_ERROR;
        // Any state change or completed request restarts the not-ready count
        if (state_d != state_q || mem.MEM_READY || !wait_st) cnt_d = 8'd0;
        else                                                 cnt_d = cnt_q + 8'd1;
    end

    assign mem.MEM_REQ   = mem_req;
    assign mem.MEM_WRITE = mem_write;
    assign ALU_OP        = ALU_OP_W'(alu_op);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed per-cycle output checks of multicycle_control_unit
module tb_multicycle_control_unit;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic [5:0] OPCODE, FUNCT;
    logic       ZERO;
    logic       I_OR_D, IR_WRITE, PC_WRITE, REG_DST, REG_WRITE, MEM2REG, EX_TOP, ALU_SRC_A;
    logic       ILLEGAL, ERR;
    logic [1:0] PC_SRC, ALU_SRC_B;
    logic [3:0] ALU_OP;
    int         checks = 0;
    int         errors = 0;

    always #5 CLK = ~CLK;

    multicycle_control_unit_if mif ();

    multicycle_control_unit #(.ALU_OP_W(4), .TIMEOUT_CYCLES(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO), .mem(mif),
        .I_OR_D(I_OR_D), .IR_WRITE(IR_WRITE), .PC_WRITE(PC_WRITE), .PC_SRC(PC_SRC),
        .REG_DST(REG_DST), .REG_WRITE(REG_WRITE), .MEM2REG(MEM2REG), .EX_TOP(EX_TOP),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP),
        .ILLEGAL(ILLEGAL), .ERR(ERR)
    );

    // {req,wr,iord,irw,pcw,pcsrc,rdst,rw,m2r,ext,asa,asb,aop,ill,err}
    wire [19:0] outs = {mif.MEM_REQ, mif.MEM_WRITE, I_OR_D, IR_WRITE, PC_WRITE, PC_SRC,
                        REG_DST, REG_WRITE, MEM2REG, EX_TOP, ALU_SRC_A, ALU_SRC_B, ALU_OP,
                        ILLEGAL, ERR};

    localparam logic [19:0] E_ZERO     = 20'b0;
    localparam logic [19:0] E_FETCH_R  = 20'b1_0_0_1_1_00_0_0_0_0_0_01_0010_0_0;
    localparam logic [19:0] E_FETCH_W  = 20'b1_0_0_0_0_00_0_0_0_0_0_01_0010_0_0;
    localparam logic [19:0] E_DECODE   = 20'b0_0_0_0_0_00_0_0_0_1_0_11_0010_0_0;
    localparam logic [19:0] E_DEC_ILL  = 20'b0_0_0_0_0_00_0_0_0_1_0_11_0010_1_0;
    localparam logic [19:0] E_EXEC_ADD = 20'b0_0_0_0_0_00_0_0_0_0_1_00_0010_0_0;
    localparam logic [19:0] E_EXEC_SLT = 20'b0_0_0_0_0_00_0_0_0_0_1_00_0111_0_0;
    localparam logic [19:0] E_EXEC_BAD = 20'b0_0_0_0_0_00_0_0_0_0_1_00_0000_1_0;
    localparam logic [19:0] E_ALUWB    = 20'b0_0_0_0_0_00_1_1_1_0_0_00_0000_0_0;
    localparam logic [19:0] E_MEMADR   = 20'b0_0_0_0_0_00_0_0_0_0_1_10_0010_0_0;
    localparam logic [19:0] E_MEMRD    = 20'b1_0_1_0_0_00_0_0_0_0_0_00_0000_0_0;
    localparam logic [19:0] E_MEMWB    = 20'b0_0_0_0_0_00_0_1_0_0_0_00_0000_0_0;
    localparam logic [19:0] E_MEMWR    = 20'b1_1_1_0_0_00_0_0_0_0_0_00_0000_0_0;
    localparam logic [19:0] E_ADDIWB   = 20'b0_0_0_0_0_00_0_1_1_0_0_00_0000_0_0;
    localparam logic [19:0] E_BR_T     = 20'b0_0_0_0_1_01_0_0_0_0_1_00_0110_0_0;
    localparam logic [19:0] E_BR_N     = 20'b0_0_0_0_0_01_0_0_0_0_1_00_0110_0_0;
    localparam logic [19:0] E_JUMP     = 20'b0_0_0_0_1_10_0_0_0_0_0_00_0000_0_0;
    localparam logic [19:0] E_ERROR    = 20'b0_0_0_0_0_00_0_0_0_0_0_00_0000_0_1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [19:0] exp);
        #1;
        check(tag, {12'b0, outs}, {12'b0, exp});
        @(negedge CLK);
    endtask

    initial begin
        RST_N = 1'b0; OPCODE = 6'b0; FUNCT = 6'b100000; ZERO = 1'b0; mif.MEM_READY = 1'b1;
        @(negedge CLK);
        cyc("in_reset", E_ZERO);
        RST_N = 1'b1;
        cyc("start", E_ZERO);

        OPCODE = 6'b000000; FUNCT = 6'b100000;
        cyc("add_fetch", E_FETCH_R);  cyc("add_decode", E_DECODE);
        cyc("add_exec", E_EXEC_ADD);  cyc("add_wb", E_ALUWB);

        FUNCT = 6'b101010;
        cyc("slt_fetch", E_FETCH_R);  cyc("slt_decode", E_DECODE);
        cyc("slt_exec", E_EXEC_SLT);  cyc("slt_wb", E_ALUWB);

        OPCODE = 6'b100011;
        cyc("lw_fetch", E_FETCH_R);   cyc("lw_decode", E_DECODE);  cyc("lw_adr", E_MEMADR);
        mif.MEM_READY = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_rd_wait", E_MEMRD);
        mif.MEM_READY = 1'b1;
        cyc("lw_rd_done", E_MEMRD);   cyc("lw_wb", E_MEMWB);

        OPCODE = 6'b101011;
        cyc("sw_fetch", E_FETCH_R);   cyc("sw_decode", E_DECODE);
        cyc("sw_adr", E_MEMADR);      cyc("sw_wr", E_MEMWR);

        OPCODE = 6'b001000;
        cyc("addi_fetch", E_FETCH_R); cyc("addi_decode", E_DECODE);
        cyc("addi_ex", E_MEMADR);     cyc("addi_wb", E_ADDIWB);

        OPCODE = 6'b000100; ZERO = 1'b1;
        cyc("beq_t_fetch", E_FETCH_R); cyc("beq_t_decode", E_DECODE); cyc("beq_t_br", E_BR_T);
        ZERO = 1'b0;
        cyc("beq_n_fetch", E_FETCH_R); cyc("beq_n_decode", E_DECODE); cyc("beq_n_br", E_BR_N);

        OPCODE = 6'b000010;
        cyc("j_fetch", E_FETCH_R);    cyc("j_decode", E_DECODE);   cyc("j_jump", E_JUMP);

        OPCODE = 6'b111111;
        cyc("ill_fetch", E_FETCH_R);  cyc("ill_decode", E_DEC_ILL);

        OPCODE = 6'b000000; FUNCT = 6'b000001;
        cyc("badfn_fetch", E_FETCH_R); cyc("badfn_decode", E_DECODE);
        cyc("badfn_exec", E_EXEC_BAD);

        OPCODE = 6'b000101; ZERO = 1'b0;
        cyc("bne_fetch", E_FETCH_R);
`ifdef CU_BNE_EN
        cyc("bne_decode", E_DECODE);  cyc("bne_n_br", E_BR_T);
        ZERO = 1'b1;
        cyc("bne_t_fetch", E_FETCH_R); cyc("bne_t_decode", E_DECODE); cyc("bne_t_br", E_BR_N);
`else
        cyc("bne_illegal", E_DEC_ILL);
`endif

        OPCODE = 6'b000100; ZERO = 1'b1;
        cyc("beq2_fetch", E_FETCH_R); cyc("beq2_decode", E_DECODE); cyc("beq2_br", E_BR_T);

        OPCODE = 6'b000000; FUNCT = 6'b100000; mif.MEM_READY = 1'b0;
        for (int i = 0; i < 4; i++) cyc("to_fetch_wait", E_FETCH_W);
        cyc("to_error", E_ERROR);
        cyc("to_error_hold", E_ERROR);
        mif.MEM_READY = 1'b1;
        cyc("to_error_ready", E_ERROR);

        RST_N = 1'b0;
        cyc("reset2", E_ZERO);
        RST_N = 1'b1;
        cyc("start2", E_ZERO);
        cyc("resume_fetch", E_FETCH_R);
        cyc("resume_decode", E_DECODE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle MIPS control FSM, successor to the single-cycle control decoder. It sequences each instruction over several cycles with a shared ALU and one unified memory port. The memory port uses a request/ready handshake with a parametrised timeout. It sits between the instruction register and the datapath muxes, register file, ALU and memory port.

## Interface
- `ALU_OP_W`, 4: width of `ALU_OP`.
- `TIMEOUT_CYCLES`, 15: maximum consecutive not-ready cycles tolerated on a memory request. Range 1..255.
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `OPCODE` in 6: IR[31:26]. Valid from DECODE onward.
- `FUNCT` in 6: IR[5:0].
- `ZERO` in 1: ALU zero flag.
- `MEM_READY` in 1: memory completes the current request this cycle.
- `MEM_REQ` out 1: memory request.
- `MEM_WRITE` out 1: request is a write.
- `I_OR_D` out 1: address select. 0 = PC, 1 = ALU result register.
- `IR_WRITE` out 1: load the instruction register.
- `PC_WRITE` out 1: load the PC.
- `PC_SRC` out 2: PC source. 00 = ALU, 01 = ALU-out register (branch target), 10 = jump target.
- `REG_DST` out 1: destination register select. 1 = rd, 0 = rt.
- `REG_WRITE` out 1: register file write enable.
- `MEM2REG` out 1: write-back select. 1 = ALU-out, 0 = memory data.
- `EX_TOP` out 1: immediate extension. 1 = sign-extend, 0 = zero-extend.
- `ALU_SRC_A` out 1: ALU A select. 0 = PC, 1 = rs.
- `ALU_SRC_B` out 2: ALU B select. 00 = rt, 01 = const 4, 10 = extended immediate, 11 = extended immediate << 2.
- `ALU_OP` out ALU_OP_W: ALU operation. and = 0000, or = 0001, add = 0010, sub = 0110, slt = 0111.
- `ILLEGAL` out 1: one-cycle pulse on an unsupported opcode or funct.
- `ERR` out 1: sticky memory timeout flag.

## Operation
- States: START, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, ERROR.
- Outputs are Moore outputs decoded from state. Exceptions: `IR_WRITE` and `PC_WRITE` in FETCH are gated by `MEM_READY`; `PC_WRITE` in BRANCH is gated by `ZERO`.
- START: all outputs 0. Go to FETCH.
- FETCH: `MEM_REQ`=1, `I_OR_D`=0, `ALU_SRC_A`=0, `ALU_SRC_B`=01, `ALU_OP`=add, `PC_SRC`=00.
  - If `MEM_READY`=1: `IR_WRITE`=1 and `PC_WRITE`=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: `ALU_SRC_A`=0, `ALU_SRC_B`=11, `ALU_OP`=add, `EX_TOP`=1. Dispatch on `OPCODE`:
  - 000000 → EXEC
  - 100011 (lw) and 101011 (sw) → MEMADR
  - 001000 (addi) → ADDIEX
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - anything else → FETCH, with `ILLEGAL`=1 for that cycle.
- MEMADR: `ALU_SRC_A`=1, `ALU_SRC_B`=10, `ALU_OP`=add, `EX_TOP`=0. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `MEM_REQ`=1, `I_OR_D`=1. Wait for `MEM_READY`, then go to MEMWB.
- MEMWB: `REG_WRITE`=1, `REG_DST`=0, `MEM2REG`=0. Go to FETCH.
- MEMWR: `MEM_REQ`=1, `MEM_WRITE`=1, `I_OR_D`=1. Wait for `MEM_READY`, then go to FETCH.
- EXEC: `ALU_SRC_A`=1, `ALU_SRC_B`=00. `ALU_OP` is decoded from `FUNCT`: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - Supported funct → ALUWB.
  - Unknown funct → `ALU_OP`=0, `ILLEGAL`=1, go to FETCH.
- ALUWB: `REG_WRITE`=1, `REG_DST`=1, `MEM2REG`=1. Go to FETCH.
- ADDIEX: `ALU_SRC_A`=1, `ALU_SRC_B`=10, `ALU_OP`=add, `EX_TOP`=0. Go to ADDIWB.
- ADDIWB: `REG_WRITE`=1, `REG_DST`=0, `MEM2REG`=1. Go to FETCH.
- BRANCH: `ALU_SRC_A`=1, `ALU_SRC_B`=00, `ALU_OP`=sub, `PC_SRC`=01, `PC_WRITE`=`ZERO`. Go to FETCH.
- JUMP: `PC_SRC`=10, `PC_WRITE`=1. Go to FETCH.
- Timeout counter: 8 bits. It increments each cycle a wait state (FETCH, MEMRD, MEMWR) has `MEM_REQ`=1 and `MEM_READY`=0. It clears on `MEM_READY`=1 and on any state change.
  - When the count equals `TIMEOUT_CYCLES` and `MEM_READY` is still 0, go to ERROR.
- ERROR: all outputs 0 except `ERR`=1. Exit only via reset.

## Timing
- Reset (async assert): state goes to START, counter to 0. Every output is 0 while `RST_N`=0 and for the first cycle after release.
- Latencies with zero-wait memory, counted in cycles including FETCH:
  - R-type 4, addi 4, sw 4, lw 5, beq 3, j 3, illegal 2.
- Each not-ready cycle in a wait state adds one cycle of latency.
- Asserting `MEM_READY` in the same cycle as the timeout threshold completes the request; no error is raised.
- Reset mid-instruction aborts the instruction. No write strobe is asserted during reset or in START.

## Configuration
- `CU_BNE_EN` defined:
  - DECODE also dispatches opcode 000101 (bne) to BRANCH.
  - The opcode is latched in a 1-bit register at DECODE.
  - In BRANCH, `PC_WRITE` = `ZERO` for beq and `~ZERO` for bne.
- `CU_BNE_EN` undefined: opcode 000101 is illegal and no latch register exists.

## Structure
- Package `cu_pkg` holds:
  - the state enum;
  - opcode and funct localparams;
  - ALU_OP encodings;
  - `ALU_SRC_B` and `PC_SRC` select encodings.
- Sub-module `alu_decoder`: combinational `FUNCT` → `ALU_OP` plus a valid bit. Used in EXEC.

## Test plan
- R-type add with `MEM_READY` tied to 1 → states FETCH, DECODE, EXEC, ALUWB. `REG_WRITE`=1 and `REG_DST`=1 only in cycle 4. `ALU_OP`=0010 in EXEC.
- lw with `MEM_READY` low for 3 cycles in MEMRD → 8 cycles total. Single `REG_WRITE` with `MEM2REG`=0.
- beq with `ZERO`=1 → `PC_WRITE`=1 and `PC_SRC`=01 in cycle 3. Repeat with `ZERO`=0 → `PC_WRITE`=0 in cycle 3.
- Opcode 111111 → `ILLEGAL` pulses in cycle 2, then FETCH in cycle 3. Repeat with R-type funct 000001 → `ILLEGAL` pulses in EXEC.
- `TIMEOUT_CYCLES`=3 with `MEM_READY`=0 in FETCH → `ERR`=1 after 4 FETCH cycles and held. `RST_N` pulse → outputs 0, normal fetch resumes.
- With `CU_BNE_EN` defined: opcode 000101 with `ZERO`=0 → `PC_WRITE`=1 in BRANCH. Without it → `ILLEGAL`.
